t03_nes_poll_ctrl: RTL and testbench

T03_NES_POLL_CTRL -- requirements
Module: t03_nes_poll_ctrl

---
 rtl/t03_nes_pkg.sv | 22 ++
 rtl/t03_sync2.sv | 22 ++
 rtl/t03_nes_poll_ctrl.sv | 163 ++++++++++++++++
 tb/tb_t03_nes_poll_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/t03_nes_pkg.sv
// Shared types and default timing constants for the NES controller poller.
package t03_nes_pkg;

  // Defaults assume a 10 MHz system clock: 6 us nes_clk half-period, 60 Hz polls
  localparam int DEFAULT_CLK_DIV     = 60;
  localparam int DEFAULT_POLL_CYCLES = 166667;

  // A standard pad reports eight buttons per poll
  localparam int BUTTON_COUNT = 8;
  localparam logic [2:0] LAST_BIT = 3'(BUTTON_COUNT - 1);

  // Poll sequencer states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    SAMPLE   = 3'd2,
    CLK_LOW  = 3'd3,
    CLK_HIGH = 3'd4,
    DONE     = 3'd5
  } nes_state_t;

endpackage

// File: rtl/t03_sync2.sv
// Two-flop synchronizer bringing the asynchronous pad data into the clk domain.
module t03_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Both stages clear on reset so data reads 0 until the pad is sampled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/t03_nes_poll_ctrl.sv
// NES controller poller: issues the latch pulse, eight shift clocks and
// per-bit capture strobes, either on request or from a free-running timer.
module t03_nes_poll_ctrl
  import t03_nes_pkg::*;
#(
  parameter int CLK_DIV     = DEFAULT_CLK_DIV,
  parameter int POLL_CYCLES = DEFAULT_POLL_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic poll_en,
  input  logic start,
  input  logic nes_data,
  output logic nes_latch,
  output logic nes_clk,
  output logic data,
  output logic button_en,
  output logic finished,
  output logic busy
);

  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int TMR_W = $clog2(POLL_CYCLES);

  localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(POLL_CYCLES - 1);

  nes_state_t       state;
  nes_state_t       state_next;
  logic [CNT_W-1:0] phase_cnt;
  logic [2:0]       bit_cnt;
  logic [TMR_W-1:0] poll_tmr;
  logic             poll_pending;
  logic             poll_tick;
  logic             launch;

  t03_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (nes_data),
    .q     (data)
  );

  assign poll_tick = (poll_tmr == TMR_LAST) && poll_en;
  assign launch    = (state == IDLE) && (start || poll_pending);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: latch, then eight samples separated by full nes_clk periods
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start || poll_pending) begin
          state_next = LATCH;
        end
      end
      LATCH: begin
        if (phase_cnt == LATCH_LAST) begin
          state_next = SAMPLE;
        end
      end
      SAMPLE: begin
        if (bit_cnt == LAST_BIT) begin
          state_next = DONE;
        end else begin
          state_next = CLK_LOW;
        end
      end
      CLK_LOW: begin
        if (phase_cnt == HALF_LAST) begin
          state_next = CLK_HIGH;
        end
      end
      CLK_HIGH: begin
        if (phase_cnt == HALF_LAST) begin
          state_next = SAMPLE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the current state only
  always_comb begin
    nes_latch = 1'b0;
    nes_clk   = 1'b1;
    button_en = 1'b0;
    finished  = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE:     busy      = 1'b0;
      LATCH:    nes_latch = 1'b1;
      SAMPLE:   button_en = 1'b1;
      CLK_LOW:  nes_clk   = 1'b0;
      CLK_HIGH: nes_clk   = 1'b1;
      DONE:     finished  = 1'b1;
      default:  busy      = 1'b0;
    endcase
  end

  // Phase counter times the latch pulse and each nes_clk half; restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_cnt <= '0;
    end else if (state_next != state) begin
      phase_cnt <= '0;
    end else if (state == LATCH || state == CLK_LOW || state == CLK_HIGH) begin
      phase_cnt <= phase_cnt + 1'b1;
    end else begin
      phase_cnt <= '0;
    end
  end

  // Bit counter tracks which button is being captured; cleared when the poll ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (state == SAMPLE) begin
      bit_cnt <= bit_cnt + 3'd1;
    end else if (state == DONE) begin
      bit_cnt <= '0;
    end
  end

  // Free-running poll timer, independent of the sequencer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_tmr <= '0;
    end else if (poll_tmr == TMR_LAST) begin
      poll_tmr <= '0;
    end else begin
      poll_tmr <= poll_tmr + 1'b1;
    end
  end

  // Single-entry request flag; a launch consumes it, so a coincident tick is absorbed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      poll_pending <= 1'b0;
    end else if (!poll_en) begin
      poll_pending <= 1'b0;
    end else if (launch) begin
      poll_pending <= 1'b0;
    end else if (poll_tick) begin
      poll_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_t03_nes_poll_ctrl.sv
// Self-checking bench for t03_nes_poll_ctrl with CLK_DIV=4, POLL_CYCLES=200.
module tb_t03_nes_poll_ctrl;

  localparam int D    = 4;
  localparam int PC   = 200;
  localparam int PLEN = 16 * D + 9;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic poll_en  = 1'b0;
  logic start    = 1'b0;
  logic nes_data = 1'b1;
  logic nes_latch, nes_clk, data, button_en, finished, busy;

  always #5 clk = ~clk;

  t03_nes_poll_ctrl #(
    .CLK_DIV     (D),
    .POLL_CYCLES (PC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .poll_en   (poll_en),
    .start     (start),
    .nes_data  (nes_data),
    .nes_latch (nes_latch),
    .nes_clk   (nes_clk),
    .data      (data),
    .button_en (button_en),
    .finished  (finished),
    .busy      (busy)
  );

  // Controller pad: latch loads bit 0, each rising nes_clk presents the next bit
  logic [7:0] pad_bits = 8'b0100_1101;
  int         pad_idx  = 8;
  logic       pad_prev_clk = 1'b1;

  always @(negedge clk) begin
    if (nes_latch) pad_idx <= 0;
    else if (nes_clk && !pad_prev_clk && pad_idx < 8) pad_idx <= pad_idx + 1;
    pad_prev_clk <= nes_clk;
    nes_data <= (pad_idx < 8) ? pad_bits[pad_idx] : 1'b1;
  end

  // Reference model: a poll is a window of PLEN cycles indexed by offset k
  logic m_idle = 1'b1;
  int   m_k    = 0;
  logic m_pend = 1'b0;
  int   m_tmr  = 0;
  logic m_s1   = 1'b0;
  logic m_s2   = 1'b0;
  logic m_launch;

  assign m_launch = m_idle && (start || m_pend);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle <= 1'b1; m_k <= 0; m_pend <= 1'b0; m_tmr <= 0; m_s1 <= 1'b0; m_s2 <= 1'b0;
    end else begin
      m_s1  <= nes_data;
      m_s2  <= m_s1;
      m_tmr <= (m_tmr + 1) % PC;
      if (!poll_en) m_pend <= 1'b0;
      else if (m_launch) m_pend <= 1'b0;
      else if (m_tmr == PC - 1) m_pend <= 1'b1;
      if (m_launch) begin
        m_idle <= 1'b0; m_k <= 0;
      end else if (!m_idle) begin
        if (m_k == PLEN - 1) m_idle <= 1'b1;
        else m_k <= m_k + 1;
      end
    end
  end

  // Outputs implied by a poll offset: {nes_latch, nes_clk, button_en, finished, busy, data}
  function automatic logic [5:0] expect_out(input logic idle, input int k, input logic d);
    logic lat, clk_o, btn, fin, bsy;
    bsy   = !idle;
    lat   = !idle && (k < 2 * D);
    btn   = !idle && (k >= 2 * D) && (k <= 16 * D + 7) && (((k - 2 * D) % (2 * D + 1)) == 0);
    clk_o = !(!idle && (k > 2 * D) && (k < 16 * D + 7) && (((k - 2 * D - 1) % (2 * D + 1)) < D));
    fin   = !idle && (k == PLEN - 1);
    return {lat, clk_o, btn, fin, bsy, d};
  endfunction

  logic [5:0] act_vec, exp_vec;
  assign act_vec = {nes_latch, nes_clk, button_en, finished, busy, data};
  assign exp_vec = expect_out(m_idle, m_k, m_s2);

  // Literal-check mailbox posted by the stimulus, consumed by the compare process
  string       lit_name = "";
  logic [31:0] lit_act  = '0;
  logic [31:0] lit_exp  = '0;
  int          lit_seq  = 0;
  int          lit_done = 0;

  int vectors     = 0;
  int miscompares = 0;

  // Compare process: model vs DUT every cycle, plus any posted literal expectation
  always @(negedge clk) begin
    if (act_vec !== exp_vec)
      $display("[TB] FAIL cycle_outputs @%0t: got %b, want %b", $time, act_vec, exp_vec);
    if (lit_seq != lit_done) begin
      lit_done <= lit_seq;
      if (lit_act !== lit_exp)
        $display("[TB] FAIL %s: got %0d, want %0d", lit_name, lit_act, lit_exp);
    end
    vectors <= vectors + 1 + ((lit_seq != lit_done) ? 1 : 0);
    miscompares <= miscompares + ((act_vec !== exp_vec) ? 1 : 0)
                 + (((lit_seq != lit_done) && (lit_act !== lit_exp)) ? 1 : 0);
  end

  // Event monitor: cumulative counts of observed strobes
  int         cyc = 0, n_btn = 0, n_fin = 0, n_busy = 0, n_launch = 0, n_latch = 0, n_fall = 0;
  int         last_btn = 0, last_fin = 0;
  logic [7:0] cap = '0;
  logic       prev_busy = 1'b0, prev_nclk = 1'b1;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (button_en) begin
      n_btn <= n_btn + 1; last_btn <= cyc; cap <= {cap[6:0], data};
    end
    if (finished) begin
      n_fin <= n_fin + 1; last_fin <= cyc;
    end
    if (busy) n_busy <= n_busy + 1;
    if (busy && !prev_busy) n_launch <= n_launch + 1;
    if (nes_latch) n_latch <= n_latch + 1;
    if (!nes_clk && prev_nclk) n_fall <= n_fall + 1;
    prev_busy <= busy;
    prev_nclk <= nes_clk;
  end

  int s_btn, s_fin, s_busy, s_launch, s_latch, s_fall;

  task automatic snap();
    s_btn = n_btn; s_fin = n_fin; s_busy = n_busy;
    s_launch = n_launch; s_latch = n_latch; s_fall = n_fall;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    lit_name = name;
    lit_act  = act;
    lit_exp  = exp;
    lit_seq  = lit_seq + 1;
    @(negedge clk);
    #1;
  endtask

  task automatic apply_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic wait_model_tmr(input int v);
    int i;
    for (i = 0; i < 2 * PC && m_tmr != v; i++) step(1);
    if (m_tmr != v) check_output("timer_align", m_tmr, v);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  logic a_clk, a_busy, a_fin;

  initial begin
    // Reset state
    step(3);
    check_output("reset_nes_clk", nes_clk, 1);
    check_output("reset_other_outputs", {nes_latch, button_en, finished, busy, data}, 0);
    rst_n = 1'b1;

    // Idle with polling disabled
    snap();
    step(500);
    check_output("idle_no_launch", n_launch - s_launch, 0);
    check_output("idle_no_button", n_btn - s_btn, 0);

    // Single requested poll
    snap();
    apply_start();
    step(PLEN + 10);
    check_output("poll_busy_cycles", n_busy - s_busy, 73);
    check_output("poll_latch_cycles", n_latch - s_latch, 8);
    check_output("poll_button_count", n_btn - s_btn, 8);
    check_output("poll_finished_count", n_fin - s_fin, 1);
    check_output("finished_after_8th", last_fin - last_btn, 1);
    check_output("poll_data_bits", cap, 8'hB2);

    // Periodic polling over five timer periods
    wait_model_tmr(10);
    snap();
    poll_en = 1'b1;
    step(1000);
    poll_en = 1'b0;
    step(100);
    check_output("auto_poll_count", n_launch - s_launch, 5);
    check_output("auto_button_count", n_btn - s_btn, 40);
    check_output("auto_finished_count", n_fin - s_fin, 5);

    // start while busy is ignored
    snap();
    apply_start();
    step(19);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(PLEN + 60);
    check_output("busy_start_ignored", n_launch - s_launch, 1);
    check_output("busy_start_finished", n_fin - s_fin, 1);

    // Timer tick mid-poll queues exactly one follow-up poll
    wait_model_tmr(150);
    snap();
    start = 1'b1;
    poll_en = 1'b1;
    step(1);
    start = 1'b0;
    step(PLEN + 5);
    poll_en = 1'b0;
    step(PLEN + 20);
    check_output("queued_tick_polls", n_launch - s_launch, 2);
    check_output("queued_tick_busy", n_busy - s_busy, 2 * PLEN);
    check_output("queued_tick_finished", n_fin - s_fin, 2);

    // Reset during the third CLK_LOW abandons the poll
    snap();
    apply_start();
    for (int i = 0; i < 200 && (n_fall - s_fall) < 3; i++) step(1);
    check_output("third_clk_low_seen", n_fall - s_fall, 3);
    #1;
    rst_n = 1'b0;
    #1;
    a_clk = nes_clk; a_busy = busy; a_fin = finished;
    check_output("midreset_nes_clk", a_clk, 1);
    check_output("midreset_busy", a_busy, 0);
    check_output("midreset_finished", a_fin, 0);
    rst_n = 1'b1;
    step(100);
    check_output("midreset_no_finished", n_fin - s_fin, 0);
    snap();
    apply_start();
    step(PLEN + 10);
    check_output("post_reset_buttons", n_btn - s_btn, 8);
    check_output("post_reset_finished", n_fin - s_fin, 1);
    check_output("post_reset_data", cap, 8'hB2);

    // start coincident with timer wrap launches a single poll
    wait_model_tmr(PC - 1);
    snap();
    start = 1'b1;
    poll_en = 1'b1;
    step(1);
    start = 1'b0;
    step(150);
    poll_en = 1'b0;
    step(20);
    check_output("coincident_single_poll", n_launch - s_launch, 1);
    check_output("coincident_finished", n_fin - s_fin, 1);
    check_output("final_idle", busy, 0);

    step(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
